// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// The fetch PC issues word requests to instruction memory. Up to DEPTH words
// can be in flight or buffered at once. Returned words queue in an in-order
// buffer that feeds decode. A redirect flushes the buffer and marks every
// outstanding response stale; the RUN/DRAIN state machine discards those
// stale responses as they arrive.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives while the buffer is empty drives instr_* in the same cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counters also hold DEPTH+1. That value occurs when a grant lands in a
  // redirect cycle while the window is already full.
  localparam int unsigned CW = $clog2(DEPTH + 2);

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [31:2]   pc_q, pc_d;
  logic [31:2]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:2]   buf_pc_q    [DEPTH];

  logic buf_empty;
  logic buf_full;
  logic gnt_fire;
  logic rv_any;
  logic rv_live;
  logic bypass;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Memory handshake qualification and request generation.
  always_comb begin
    buf_empty = (count_q == '0);
    buf_full  = (count_q == CW'(DEPTH));
    imem_req  = !reset && !redirect && ((count_q + inflight_q) < CW'(DEPTH));
    imem_addr = {pc_q, 2'b00};
    // A grant that arrives in the redirect cycle still leaves a response outstanding.
    gnt_fire  = !reset && imem_gnt && (imem_req || redirect);
    rv_any    = !reset && imem_rvalid;
    rv_live   = rv_any && !redirect && (state_q == RUN);
  end

`ifdef FETCH_BYPASS_EN
  // Decode outputs: the buffer head, or the arriving word when the buffer is empty.
  always_comb begin
    bypass      = rv_live && buf_empty;
    instr_valid = !reset && (!buf_empty || bypass);
    instr       = bypass ? imem_rdata : buf_instr_q[rd_ptr_q];
    instr_pc    = bypass ? {resp_pc_q, 2'b00} : {buf_pc_q[rd_ptr_q], 2'b00};
    pc_plus8    = instr_pc + 32'd8;
    pop         = !reset && !buf_empty && instr_ready;
    push        = rv_live && !(bypass && instr_ready);
  end
`else
  // Decode outputs come only from registered buffer state.
  always_comb begin
    bypass      = 1'b0;
    instr_valid = !reset && !buf_empty;
    instr       = buf_instr_q[rd_ptr_q];
    instr_pc    = {buf_pc_q[rd_ptr_q], 2'b00};
    pc_plus8    = instr_pc + 32'd8;
    pop         = !reset && !buf_empty && instr_ready;
    push        = rv_live;
  end
`endif

  // Next-state computation for the PC, the counters and the buffer pointers.
  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(rv_any);
    stale_d    = stale_q;
    if (gnt_fire) begin
      pc_d = pc_q + 30'd1;
    end
    // resp_pc is the address of the next non-stale response.
    if (rv_live) begin
      resp_pc_d = resp_pc_q + 30'd1;
    end
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if ((state_q == DRAIN) && rv_any) begin
      stale_d = stale_q - CW'(1);
    end
    if (redirect) begin
      pc_d      = redirect_pc[31:2];
      resp_pc_d = redirect_pc[31:2];
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      stale_d   = inflight_d;
    end
  end

  // RUN/DRAIN next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (redirect && (inflight_d != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stale_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC[31:2];
      resp_pc_q  <= RESET_PC[31:2];
      count_q    <= '0;
      inflight_q <= '0;
      stale_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage: write the response word and its address at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Flow-control sanity checks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && buf_full));
      assert (!(rv_any && (inflight_q == '0)));
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL take parameter DEPTH, default 2, the instruction buffer entries and maximum in-flight plus buffered fetches.
REQ-003 The block SHALL have ports, in order:
  clk  in  1  clock, rising edge;
  reset  in  1  synchronous, active-high;
  imem_req  out  1  fetch request;
  imem_addr  out  32  word-aligned fetch address;
  imem_gnt  in  1  request accepted this cycle;
  imem_rvalid  in  1  read data valid, in request order;
  imem_rdata  in  32  instruction word;
  redirect  in  1  branch or PC write taken (PCS path);
  redirect_pc  in  32  new fetch address;
  instr_valid  out  1  instr holds a valid instruction;
  instr_ready  in  1  decode stage accepts instr;
  instr  out  32  instruction to decode (Op/Funct/Rd source);
  instr_pc  out  32  address of instr;
  pc_plus8  out  32  instr_pc+8, the R15 read value.

Function
REQ-004 The block SHALL hold fetch PC `pc`, advancing by 4 on each cycle with imem_req&imem_gnt and no redirect.
REQ-005 The block SHALL assert imem_req when not in reset, redirect is low, and buf_count+inflight < DEPTH.
REQ-006 imem_addr SHALL equal {pc[31:2],2'b00} and SHALL remain stable while imem_req is high without imem_gnt.
REQ-007 `inflight` SHALL increment on each grant, decrement on each rvalid, and stay unchanged when both occur in the same cycle.
REQ-008 A non-stale rvalid SHALL push {imem_rdata, its request address} into the in-order FIFO buffer.
REQ-009 instr_valid SHALL be high iff the buffer is non-empty; instr, instr_pc and pc_plus8 SHALL reflect the head entry.
REQ-010 A pop SHALL occur on instr_valid&instr_ready; a push and a pop SHALL be allowed in the same cycle at any occupancy.
REQ-011 Buffer overflow SHALL be impossible by REQ-005; a push into a full buffer without a pop is an assertion failure.
REQ-012 On redirect, the block SHALL, at the next edge, set pc to {redirect_pc[31:2],2'b00}, empty the buffer, and set `stale` to the inflight value after that edge.
REQ-013 A request granted in the redirect cycle SHALL count as stale; an rvalid in the redirect cycle SHALL be discarded.
REQ-014 While stale>0, each rvalid SHALL be discarded and SHALL decrement stale; stale responses never reach instr.
REQ-015 A state machine SHALL have states RUN (stale==0) and DRAIN (stale>0), with RUN->DRAIN on redirect leaving inflight>0 and DRAIN->RUN when stale reaches 0; requests to the new PC SHALL be allowed in DRAIN.
REQ-016 A redirect during DRAIN SHALL re-evaluate stale per REQ-012.
REQ-017 Without bypass, the latency from non-stale rvalid to instr_valid SHALL be one cycle.

Reset
REQ-018 While reset is high at a clock edge, the block SHALL set pc=RESET_PC, empty the buffer, and set inflight=0, stale=0, state=RUN.
REQ-019 During reset, imem_req=0 and instr_valid=0; responses arriving while reset is high SHALL be ignored.
REQ-020 Reset SHALL take priority over redirect and all handshakes, including reset asserted mid-request.

Configuration
REQ-021 With FETCH_BYPASS_EN defined, a non-stale rvalid with the buffer empty SHALL drive instr_valid, instr and instr_pc combinationally in the same cycle, and SHALL be written to the buffer only if instr_ready is low.
REQ-022 Without FETCH_BYPASS_EN, there SHALL be no combinational path from imem_* inputs to instr_* outputs.

Verification
REQ-023 Release reset with gnt held at 1, rvalid one cycle after each gnt, and ready=1 -> imem_addr sequence 0,4,8; instr_pc 0 and pc_plus8 8 appear one cycle after the first rvalid.
REQ-024 Set ready=0 with DEPTH=2 -> at most 2 requests issued; imem_req falls until a pop; no word is lost or reordered.
REQ-025 Issue 2 grants to 0x10 and 0x14, then redirect to 0x103 -> both responses discarded, next imem_addr 0x100, and the first instr_pc is 0x100.
REQ-026 Assert redirect in the same cycle as gnt and rvalid -> the rvalid is dropped, the granted request is counted stale, and state is DRAIN with stale=1.
REQ-027 Assert reset in the middle of the 0x20 request while buffer holds 1 entry -> next cycle imem_req=0, instr_valid=0, and pc=RESET_PC.
REQ-028 Run with FETCH_BYPASS_EN, the buffer empty, and ready=1 -> instr_valid is high in the same cycle as rvalid; without the macro it is high one cycle later.
